// File: rtl/level_seq_pkg.sv
// Shared types, default constants and arithmetic helpers for the level sequencer.
package level_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    PLAY = 3'd2,
    EVAL = 3'd3,
    WON  = 3'd4,
    LOST = 3'd5
  } state_e;

  localparam int DEF_NUM_LEVELS     = 3;
  localparam int DEF_MAX_LIVES      = 3;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_LEVEL_POINTS   = 10;
  localparam int DEF_SCORE_W        = 8;

  // Adds two unsigned values and clamps the result at max_val.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/level_sequencer_sync.sv
// Two-flop synchroniser with a rising-edge pulse for a raw button input.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic pulse_o
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic       armed_q;
  logic [1:0] warm_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      warm_q  <= 2'b00;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      warm_q <= {warm_q[0], 1'b1};
      // A button still held when reset releases must be let go before it can fire.
      if (warm_q[1] && !sync_q) armed_q <= 1'b1;
    end
  end

  assign pulse_o = sync_q & ~prev_q & armed_q;

endmodule

// File: rtl/level_sequencer.sv
// Game controller: steps the player through the level check stages, tracking lives, score and a per-attempt timer.
module level_sequencer
  import level_seq_pkg::*;
#(
  parameter int NUM_LEVELS     = DEF_NUM_LEVELS,
  parameter int MAX_LIVES      = DEF_MAX_LIVES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int LEVEL_POINTS   = DEF_LEVEL_POINTS,
  parameter int SCORE_W        = DEF_SCORE_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              check,
  input  logic [NUM_LEVELS-1:0]             level_passed,
  output logic                              lfsr_rst,
  output logic [NUM_LEVELS-1:0]             level_sel,
  output logic [$clog2(NUM_LEVELS)-1:0]     cur_level,
  output logic [1:0]                        lives,
  output logic [SCORE_W-1:0]                score,
  output logic [$clog2(TIMEOUT_CYCLES)-1:0] timer,
  output logic                              busy,
  output logic                              game_won,
  output logic                              game_over
);

  localparam int          LW        = $clog2(NUM_LEVELS);
  localparam int          TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;

  logic start_pulse;
  logic check_pulse;

  sync_edge u_sync_start (
    .clk     (clk),
    .rst     (rst),
    .async_i (start),
    .pulse_o (start_pulse)
  );

  sync_edge u_sync_check (
    .clk     (clk),
    .rst     (rst),
    .async_i (check),
    .pulse_o (check_pulse)
  );

  state_e             state_q, state_d;
  logic [LW-1:0]      cur_level_q, cur_level_d;
  logic [1:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               attempt_fail;
  logic [31:0]        level_pts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_level_q <= '0;
      lives_q     <= '0;
      score_q     <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_level_q <= cur_level_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      timer_q     <= timer_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d      = state_q;
    cur_level_d  = cur_level_q;
    lives_d      = lives_q;
    score_d      = score_q;
    timer_d      = timer_q;
    attempt_fail = 1'b0;
    level_pts    = 32'(LEVEL_POINTS) * (32'(cur_level_q) + 32'd1);

    unique case (state_q)
      IDLE, WON, LOST: begin
        if (start_pulse) begin
          state_d     = ARM;
          cur_level_d = '0;
          lives_d     = 2'(MAX_LIVES);
          score_d     = '0;
        end
      end
      ARM: begin
        timer_d = TW'(TIMEOUT_CYCLES - 1);
        state_d = PLAY;
      end
      PLAY: begin
        if (timer_q != '0) timer_d = timer_q - 1'b1;
        // A submit arriving on the last cycle still wins over the timeout.
        if (check_pulse)          state_d      = EVAL;
        else if (timer_q == '0)   attempt_fail = 1'b1;
      end
      EVAL: begin
        if (level_passed[cur_level_q]) begin
          score_d = SCORE_W'(sat_add(32'(score_q), level_pts, SCORE_MAX));
          if (cur_level_q == LW'(NUM_LEVELS - 1)) begin
            state_d = WON;
          end else begin
            cur_level_d = cur_level_q + 1'b1;
            state_d     = ARM;
          end
        end else begin
          attempt_fail = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (attempt_fail) begin
      if (lives_q <= 2'd1) begin
        lives_d = '0;
        state_d = LOST;
      end else begin
        lives_d = lives_q - 1'b1;
        state_d = ARM;
      end
    end
  end

  assign busy      = (state_q == ARM) || (state_q == PLAY) || (state_q == EVAL);
  assign lfsr_rst  = (state_q == IDLE);
  assign game_won  = (state_q == WON);
  assign game_over = (state_q == LOST);
  assign level_sel = busy ? (NUM_LEVELS'(1) << cur_level_q) : '0;
  assign cur_level = cur_level_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign timer     = timer_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: expected status snapshots are queued by the stimulus and popped by a monitor.
module tb_level_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic       check_btn;
  logic [2:0] level_passed;
  logic       lfsr_rst;
  logic [2:0] level_sel;
  logic [1:0] cur_level;
  logic [1:0] lives;
  logic [7:0] score;
  logic [2:0] timer;
  logic       busy;
  logic       game_won;
  logic       game_over;

  level_sequencer #(
    .NUM_LEVELS     (3),
    .MAX_LIVES      (3),
    .TIMEOUT_CYCLES (8),
    .LEVEL_POINTS   (10),
    .SCORE_W        (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start_btn),
    .check        (check_btn),
    .level_passed (level_passed),
    .lfsr_rst     (lfsr_rst),
    .level_sel    (level_sel),
    .cur_level    (cur_level),
    .lives        (lives),
    .score        (score),
    .timer        (timer),
    .busy         (busy),
    .game_won     (game_won),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       won;
    logic       over;
    logic       lfsr;
    logic [2:0] sel;
    logic [1:0] lvl;
    logic [1:0] lives;
    logic [7:0] score;
  } snap_t;

  int    n_total = 0;
  int    n_bad   = 0;
  snap_t exp_q[$];
  snap_t prev_snap;
  logic  mon_en = 1'b0;

  function automatic snap_t mk(input logic b, input logic w, input logic o, input logic l,
                               input logic [2:0] sel, input logic [1:0] lvl,
                               input logic [1:0] lv, input logic [7:0] sc);
    snap_t s;
    s.busy = b; s.won = w; s.over = o; s.lfsr = l;
    s.sel = sel; s.lvl = lvl; s.lives = lv; s.score = sc;
    return s;
  endfunction

  function automatic snap_t sample();
    return mk(busy, game_won, game_over, lfsr_rst, level_sel, cur_level, lives, score);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitor: every change of the observable status is one DUT response.
  always @(negedge clk) begin
    if (mon_en) begin
      snap_t cur;
      cur = sample();
      if (cur !== prev_snap) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_change: got %0h want %0h", cur, prev_snap);
        end else begin
          check("status", 32'(cur), 32'(exp_q.pop_front()));
        end
        prev_snap = cur;
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk); #1;
    end
    timeout_fail("drain");
    exp_q.delete();
  endtask

  task automatic wait_timer(input logic [2:0] v);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy && timer == v) return;
    end
    timeout_fail("wait_timer");
  endtask

  task automatic press_check(input int hold);
    check_btn = 1'b1;
    repeat (hold) @(negedge clk);
    check_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Presses start and checks the synchroniser latency and the first PLAY timer value.
  task automatic start_game();
    exp_q.push_back(mk(1, 0, 0, 0, 3'b001, 2'd0, 2'd3, 8'd0));
    start_btn = 1'b1;
    @(negedge clk);
    check("start_lat_e0", 32'(busy), 32'd0);
    start_btn = 1'b0;
    @(negedge clk);
    check("start_lat_e1", 32'(busy), 32'd0);
    @(negedge clk);
    check("start_arm", 32'(busy), 32'd1);
    @(negedge clk);
    check("timer_first_play", 32'(timer), 32'd7);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    snap_t rs;
    rs = mk(0, 0, 0, 1, 3'b000, 2'd0, 2'd0, 8'd0);
    rst = 1'b1; start_btn = 1'b0; check_btn = 1'b0; level_passed = 3'b000;
    repeat (3) @(negedge clk);
    check("reset_status", 32'(sample()), 32'(rs));
    check("reset_timer", 32'(timer), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    prev_snap = rs;
    mon_en = 1'b1;

    // Clear all three levels.
    start_game();
    level_passed = 3'b111;
    exp_q.push_back(mk(1, 0, 0, 0, 3'b010, 2'd1, 2'd3, 8'd10));
    press_check(1); wait_drain();
    exp_q.push_back(mk(1, 0, 0, 0, 3'b100, 2'd2, 2'd3, 8'd30));
    press_check(1); wait_drain();
    exp_q.push_back(mk(0, 1, 0, 0, 3'b000, 2'd2, 2'd3, 8'd60));
    press_check(1); wait_drain();
    press_check(1);
    repeat (3) @(negedge clk);

    // Fail level 0 three times; a held check gives a single attempt.
    start_game();
    level_passed = 3'b000;
    exp_q.push_back(mk(1, 0, 0, 0, 3'b001, 2'd0, 2'd2, 8'd0));
    press_check(3); wait_drain();
    exp_q.push_back(mk(1, 0, 0, 0, 3'b001, 2'd0, 2'd1, 8'd0));
    press_check(1); wait_drain();
    exp_q.push_back(mk(0, 0, 1, 0, 3'b000, 2'd0, 2'd0, 8'd0));
    press_check(1); wait_drain();

    // Timeout with no submit: miss, re-arm on the same level.
    start_game();
    exp_q.push_back(mk(1, 0, 0, 0, 3'b001, 2'd0, 2'd2, 8'd0));
    repeat (7) @(negedge clk);
    check("timer_zero", 32'(timer), 32'd0);
    check("lives_before_miss", 32'(lives), 32'd3);
    @(negedge clk);
    check("lives_after_miss", 32'(lives), 32'd2);
    @(negedge clk);
    check("timer_reload", 32'(timer), 32'd7);
    wait_drain();

    // Submit landing on timer==0 counts as a check.
    level_passed = 3'b001;
    exp_q.push_back(mk(1, 0, 0, 0, 3'b010, 2'd1, 2'd2, 8'd10));
    wait_timer(3'd2);
    press_check(1); wait_drain();

    // Only the current level's flag matters.
    level_passed = 3'b101;
    exp_q.push_back(mk(1, 0, 0, 0, 3'b010, 2'd1, 2'd1, 8'd10));
    press_check(1); wait_drain();
    level_passed = 3'b010;
    exp_q.push_back(mk(1, 0, 0, 0, 3'b100, 2'd2, 2'd1, 8'd30));
    press_check(1); wait_drain();

    // Asynchronous reset mid-game, with start held across its release.
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_timer_nonzero", 32'(timer != 3'd0), 32'd1);
    exp_q.push_back(rs);
    start_btn = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("async_reset_status", 32'(sample()), 32'(rs));
    check("async_reset_timer", 32'(timer), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_btn = ~check_btn;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_btn = (i % 4) < 2;
    end
    check_btn = 1'b0;
    check("held_start_ignored", 32'(sample()), 32'(rs));
    start_btn = 1'b0;
    repeat (6) @(negedge clk);
    start_game();

    wait_drain();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Game controller directly downstream of the level1/level2/level3 check stages.
- Consumes their LEVELn_PASSED flags and steps the player through the levels in order.
- Tracks lives, score and a per-level countdown, and holds the levels' LFSR at its seed while no game is running.
- Produces level-select, win/lose and status outputs for the display/LED stage.

Parameters:
- NUM_LEVELS, 3, number of level stages sequenced (index 0 = level1).
- MAX_LIVES, 3, lives loaded at game start (1..3).
- TIMEOUT_CYCLES, 1024, clk cycles allowed per attempt before a miss (>=2).
- LEVEL_POINTS, 10, base points; clearing level index i adds LEVEL_POINTS*(i+1).
- SCORE_W, 8, score register width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  raw user start/restart button, asynchronous to clk
- check  in  1  raw user "submit" button, asynchronous to clk
- level_passed  in  NUM_LEVELS  LEVELn_PASSED flags, bit i = level i+1
- lfsr_rst  out  1  drives the levels' LFSR reset; high in IDLE only
- level_sel  out  NUM_LEVELS  one-hot active level; zero outside ARM/PLAY/EVAL
- cur_level  out  $clog2(NUM_LEVELS)  index of current level
- lives  out  2  remaining lives
- score  out  SCORE_W  accumulated score, saturating
- timer  out  $clog2(TIMEOUT_CYCLES)  remaining cycles in current attempt
- busy  out  1  high in ARM/PLAY/EVAL
- game_won  out  1  high in WON
- game_over  out  1  high in LOST

Behaviour:
- Reset (async, any state): state=IDLE, lfsr_rst=1, level_sel=0, cur_level=0, lives=0, score=0, timer=0, busy=0, game_won=0, game_over=0.
- start and check each pass through a 2-flop synchroniser plus a rising-edge detector. A raw rise sampled at edge k produces a one-cycle pulse visible between edges k+1 and k+2; the FSM reacts at edge k+2. Held buttons give exactly one pulse.
- IDLE:
  - lfsr_rst=1.
  - On start pulse: load cur_level=0, lives=MAX_LIVES, score=0; go to ARM.
- ARM (1 cycle):
  - lfsr_rst=0; timer loads TIMEOUT_CYCLES-1; go to PLAY.
  - This is also the lives/level re-entry point after a miss.
- PLAY:
  - timer decrements by 1 each cycle and does not wrap below 0.
  - check pulse: go to EVAL. A check pulse in the same cycle as timer==0 counts as a check, not a miss.
  - timer==0 with no check pulse: treated as a failed EVAL (miss path) on the next edge.
- EVAL (1 cycle): samples level_passed[cur_level] combinationally; all other bits are ignored.
  - Passed: score += LEVEL_POINTS*(cur_level+1), saturating at 2^SCORE_W-1. If cur_level==NUM_LEVELS-1, go to WON; else cur_level++ and go to ARM.
  - Failed or miss: if lives==1, lives=0 and go to LOST; else lives-- and go to ARM on the same level.
- WON / LOST:
  - Sticky; score, lives and cur_level are frozen; lfsr_rst=0 (LFSR keeps running).
  - On start pulse: reinitialise exactly as from IDLE and go to ARM.
- start pulses in ARM/PLAY/EVAL are ignored. check pulses outside PLAY are ignored.
- level_sel = one-hot(cur_level) while busy, else 0.
- All outputs are registered or decoded from registered state; there are no combinational paths from the raw inputs.
- Reset mid-game aborts immediately; no state is retained.

Decomposition:
- Package level_seq_pkg:
  - state enum {IDLE, ARM, PLAY, EVAL, WON, LOST}, 3-bit encoding.
  - Default constants for NUM_LEVELS, MAX_LIVES, LEVEL_POINTS.
  - Saturating-add helper function.
- Sub-module sync_edge: 2-flop synchroniser plus rising-edge pulse, async active-high reset to 0. Instantiated twice (start, check).

Test Plan (TIMEOUT_CYCLES=8, defaults otherwise):
- Reset then start pulse → ARM 2 edges after the sync delay; lfsr_rst falls; level_sel=001; lives=3; timer=7 in the first PLAY cycle.
- level_passed=111 with a check in each PLAY → score 10, then 30, then 60; game_won=1; busy=0; level_sel=000; start → score=0, lives=3, cur_level=0.
- level_passed=000 with three checks on level 0 → lives 2, 1, 0; game_over=1; cur_level stays 0; score 0.
- No check for 8 PLAY cycles → miss: lives 3→2; re-ARM on the same level; timer reloads to 7.
- check edge coinciding with timer==0 while level_passed[0]=1 → EVAL pass (score=10, cur_level=1), not a miss.
- Assert rst during PLAY on level 2 → all outputs return to reset values asynchronously; check pulses and a held start button produce no action until start is released and pressed again.
